// File: rtl/multicycle_ctr.sv
// multicycle_ctr: Moore FSM sequencing a multi-cycle MIPS datapath, with retired-instruction counter
module multicycle_ctr #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opCode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemToReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUop,
  output logic [1:0]       PCSource,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  RTEXE  = 4'd6,  RTWB   = 4'd7,
    BEQ    = 4'd8,  JMP    = 4'd9,  ADDIEX = 4'd10, ADDIWB = 4'd11
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;
  // next state; unreachable encodings fall back to FETCH
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = mem_ready ? DECODE : FETCH;
      DECODE:  state_d = (opCode == OP_LW || opCode == OP_SW) ? MEMADR :
                         opCode == OP_R    ? RTEXE  :
                         opCode == OP_BEQ  ? BEQ    :
                         opCode == OP_J    ? JMP    :
                         opCode == OP_ADDI ? ADDIEX : FETCH;
      MEMADR:  state_d = opCode == OP_SW ? MEMWR : MEMRD;
      MEMRD:   state_d = mem_ready ? MEMWB : MEMRD;
      MEMWR:   state_d = mem_ready ? FETCH : MEMWR;
      RTEXE:   state_d = RTWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end
  // an instruction retires on the edge that leaves its final state
  always_comb begin
    retire = state_q == MEMWB || state_q == RTWB || state_q == BEQ || state_q == JMP ||
             state_q == ADDIWB || (state_q == MEMWR && mem_ready);
    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end
  // state and counter registers; reset overrides everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end
  // Moore decode of datapath controls; PC/IR loads and illegal_op are masked during reset
  always_comb begin
    PCWrite     = !reset && ((state_q == FETCH && mem_ready) || state_q == JMP);
    PCWriteCond = state_q == BEQ;
    IorD        = state_q == MEMRD || state_q == MEMWR;
    MemRead     = state_q == FETCH || state_q == MEMRD;
    MemWrite    = state_q == MEMWR;
    IRWrite     = !reset && state_q == FETCH && mem_ready;
    MemToReg    = state_q == MEMWB;
    RegDst      = state_q == RTWB;
    RegWrite    = state_q == MEMWB || state_q == RTWB || state_q == ADDIWB;
    ALUSrcA     = state_q == MEMADR || state_q == RTEXE || state_q == BEQ || state_q == ADDIEX;
    ALUSrcB     = state_q == FETCH  ? 2'b01 :
                  state_q == DECODE ? 2'b11 :
                  (state_q == MEMADR || state_q == ADDIEX) ? 2'b10 : 2'b00;
    ALUop       = state_q == RTEXE ? 2'b10 : state_q == BEQ ? 2'b01 : 2'b00;
    PCSource    = state_q == JMP ? 2'b10 : state_q == BEQ ? 2'b01 : 2'b00;
    illegal_op  = !reset && state_q == DECODE && state_d == FETCH;
  end
  assign state   = state_q;
  assign retired = retired_q;
endmodule

// File: tb/tb_multicycle_ctr.sv
// tb_multicycle_ctr: vector table, corner sequences and randomized run against an instruction-level model
module tb_multicycle_ctr;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BQ = 6'b000100, JP = 6'b000010, AD = 6'b001000, IL = 6'b010101;
  logic        clk = 0, reset = 1, mem_ready = 0;
  logic [5:0]  opCode = 0;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUop, PCSource;
  logic        illegal_op;
  logic [3:0]  state;
  logic [31:0] retired;
  logic [16:0] ctl;
  int n_tests = 0, n_fail = 0;

  multicycle_ctr #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opCode(opCode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUop(ALUop),
    .PCSource(PCSource), .illegal_op(illegal_op), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;
  assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst,
                RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource, illegal_op};

  typedef int iq_t[$];
  int          m_state = 0;
  logic [31:0] m_ret = 0;
  iq_t         m_q;

  function automatic iq_t path(input logic [5:0] op);
    iq_t q;
    case (op)
      LW: q = '{2, 3, 4};
      SW: q = '{2, 5};
      RT: q = '{6, 7};
      BQ: q = '{8};
      JP: q = '{9};
      AD: q = '{10, 11};
      default: ;
    endcase
    return q;
  endfunction

  function automatic logic [16:0] exp_ctl(input int s, input logic mr, input logic rst, input logic [5:0] op);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ill;
    logic [1:0] asb, aop, pcs;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ill} = '0;
    {asb, aop, pcs} = '0;
    case (s)
      0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      1:  begin asb = 2'b11; ill = (path(op).size() == 0); end
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      9:  begin pcw = 1; pcs = 2'b10; end
      10: begin asa = 1; asb = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    if (rst) {pcw, irw, ill} = '0;
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, ill};
  endfunction

  task automatic model_edge(input logic r, input logic [5:0] op, input logic mr);
    if (r) begin
      m_state = 0; m_ret = 0; m_q.delete();
    end else if ((m_state == 0 || m_state == 3 || m_state == 5) && !mr) begin
    end else if (m_state == 0) m_state = 1;
    else if (m_state == 1) begin
      m_q = path(op);
      m_state = (m_q.size() == 0) ? 0 : m_q.pop_front();
    end else if (m_q.size() == 0) begin
      m_state = 0; m_ret = m_ret + 1;
    end else m_state = m_q.pop_front();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [5:0] op, input logic mr);
    reset = r; opCode = op; mem_ready = mr;
    @(negedge clk);
    chk("model_state", {28'd0, state}, m_state);
    chk("model_ctl", {15'd0, ctl}, {15'd0, exp_ctl(m_state, mr, r, op)});
    chk("model_retired", retired, m_ret);
  endtask

  task automatic adv();
    @(posedge clk);
    model_edge(reset, opCode, mem_ready);
    #1;
  endtask

  typedef struct {
    logic rst; logic [5:0] op; logic mr;
    logic [3:0] st; logic [31:0] ret; logic pcw, irw, rw, ill;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input int rst, input logic [5:0] op, input int mr, input int st, input int ret,
                     input int pcw, input int irw, input int rw, input int ill);
    vec_t v;
    v.rst = 1'(rst); v.op = op; v.mr = 1'(mr); v.st = 4'(st); v.ret = 32'(ret);
    v.pcw = 1'(pcw); v.irw = 1'(irw); v.rw = 1'(rw); v.ill = 1'(ill);
    tbl.push_back(v);
  endtask

  initial begin
    logic [5:0] cur_op;
    add(0, LW, 1, 0, 0, 1, 1, 0, 0); add(0, LW, 1, 1, 0, 0, 0, 0, 0); add(0, LW, 1, 2, 0, 0, 0, 0, 0);
    add(0, LW, 1, 3, 0, 0, 0, 0, 0); add(0, LW, 1, 4, 0, 0, 0, 1, 0);
    add(0, RT, 1, 0, 1, 1, 1, 0, 0); add(0, RT, 1, 1, 1, 0, 0, 0, 0); add(0, RT, 1, 6, 1, 0, 0, 0, 0);
    add(0, RT, 1, 7, 1, 0, 0, 1, 0);
    add(0, AD, 1, 0, 2, 1, 1, 0, 0); add(0, AD, 1, 1, 2, 0, 0, 0, 0); add(0, AD, 1, 10, 2, 0, 0, 0, 0);
    add(0, AD, 1, 11, 2, 0, 0, 1, 0);
    add(0, BQ, 1, 0, 3, 1, 1, 0, 0); add(0, BQ, 1, 1, 3, 0, 0, 0, 0); add(0, BQ, 1, 8, 3, 0, 0, 0, 0);
    add(0, JP, 1, 0, 4, 1, 1, 0, 0); add(0, JP, 1, 1, 4, 0, 0, 0, 0); add(0, JP, 1, 9, 4, 1, 0, 0, 0);
    add(0, IL, 1, 0, 5, 1, 1, 0, 0); add(0, IL, 1, 1, 5, 0, 0, 0, 1);
    add(0, IL, 0, 0, 5, 0, 0, 0, 0); add(0, IL, 1, 0, 5, 1, 1, 0, 0);
    add(1, IL, 1, 1, 5, 0, 0, 0, 0); add(1, LW, 1, 0, 0, 0, 0, 0, 0); add(0, LW, 1, 0, 0, 1, 1, 0, 0);

    reset = 1; mem_ready = 0; opCode = 0;
    adv();
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].op, tbl[i].mr);
      chk($sformatf("vec%0d_state", i), {28'd0, state}, {28'd0, tbl[i].st});
      chk($sformatf("vec%0d_retired", i), retired, tbl[i].ret);
      chk($sformatf("vec%0d_flags", i), {28'd0, PCWrite, IRWrite, RegWrite, illegal_op},
          {28'd0, tbl[i].pcw, tbl[i].irw, tbl[i].rw, tbl[i].ill});
      adv();
    end

    drive(1, SW, 1); adv();
    for (int i = 0; i < 3; i++) begin drive(0, SW, 1); adv(); end
    for (int i = 0; i < 3; i++) begin
      drive(0, SW, 0);
      chk("sw_stall_state", {28'd0, state}, 32'd5);
      chk("sw_stall_memwrite_iord", {30'd0, MemWrite, IorD}, 32'd3);
      chk("sw_stall_retired", retired, 32'd0);
      adv();
    end
    drive(0, SW, 1); chk("sw_done_state", {28'd0, state}, 32'd5); adv();
    drive(0, LW, 1); chk("sw_retired", retired, 32'd1); chk("sw_next_state", {28'd0, state}, 32'd0); adv();
    drive(0, LW, 1); adv(); drive(0, LW, 1); adv();
    for (int i = 0; i < 2; i++) begin drive(0, LW, 0); chk("memrd_stall", {28'd0, state}, 32'd3); adv(); end
    drive(1, LW, 1);
    chk("rst_memrd_state", {28'd0, state}, 32'd3);
    chk("rst_memrd_pcw_irw", {30'd0, PCWrite, IRWrite}, 32'd0);
    adv();
    drive(1, LW, 1);
    chk("rst_fetch_state", {28'd0, state}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_fetch_pcw_irw", {30'd0, PCWrite, IRWrite}, 32'd0);
    adv();
    drive(0, LW, 1); chk("post_rst_irw", {31'd0, IRWrite}, 32'd1); adv();

    cur_op = LW;
    for (int n = 0; n < 3000; n++) begin
      if (m_state != 2) begin
        case ($urandom_range(0, 7))
          0: cur_op = LW; 1: cur_op = SW; 2: cur_op = RT; 3: cur_op = BQ;
          4: cur_op = JP; 5: cur_op = AD; default: cur_op = 6'($urandom);
        endcase
      end
      drive($urandom_range(0, 49) == 0, cur_op, $urandom_range(0, 2) != 0);
      adv();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_ctr.md
Name: multicycle_ctr

Overview:
Multi-cycle MIPS main controller. It replaces the single-cycle opcode decoder with a Moore FSM that sequences a shared-memory, single-ALU datapath over 3–5 cycles per instruction. It takes the instruction opcode from the datapath's instruction register and a memory-ready handshake. It drives every datapath enable and mux select, and keeps a retired-instruction counter for debug.

Parameters:
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
opCode  in  6  opcode field from the instruction register; valid from DECODE onward.
mem_ready  in  1  memory completes the current read/write this cycle.
PCWrite  out  1  unconditional PC load.
PCWriteCond  out  1  PC load if the ALU zero flag is set (beq).
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
MemRead  out  1  memory read request.
MemWrite  out  1  memory write request.
IRWrite  out  1  instruction register load.
MemToReg  out  1  register write data select: 1 = MDR, 0 = ALUOut.
RegDst  out  1  destination register select: 1 = rd, 0 = rt.
RegWrite  out  1  register file write enable.
ALUSrcA  out  1  ALU A select: 0 = PC, 1 = rs.
ALUSrcB  out  2  ALU B select: 00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
ALUop  out  2  00 = add, 01 = sub, 10 = funct-decoded.
PCSource  out  2  PC input select: 00 = ALU, 01 = ALUOut, 10 = jump target.
illegal_op  out  1  unsupported opcode detected in DECODE.
state  out  4  current state, for debug.
retired  out  CNT_W  count of completed instructions.

Behaviour:
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000. Every other opcode is illegal.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXE=6, RTWB=7, BEQ=8, JMP=9, ADDIEX=10, ADDIWB=11. Codes 12–15 are unreachable and return to FETCH.
- Reset: on the reset edge, state becomes FETCH and retired becomes 0. While reset is high, PCWrite, IRWrite and illegal_op are forced to 0.
- Every output not listed for a state is 0 in that state. All outputs are decoded from state, except the mem_ready gating below.
- FETCH: MemRead=1, ALUSrcB=01, IRWrite=mem_ready, PCWrite=mem_ready. Go to DECODE when mem_ready=1, else stay in FETCH.
- DECODE: ALUSrcB=11. Next state by opcode:
  - lw or sw → MEMADR.
  - R-type → RTEXE.
  - beq → BEQ.
  - j → JMP.
  - addi → ADDIEX.
  - illegal → FETCH, with illegal_op=1 combinationally for this cycle only; retired is not incremented.
- MEMADR: ALUSrcA=1, ALUSrcB=10. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Stay until mem_ready=1, then go to MEMWB.
- MEMWB: RegWrite=1, MemToReg=1, RegDst=0. Go to FETCH.
- MEMWR: MemWrite=1, IorD=1. Stay until mem_ready=1, then go to FETCH.
- RTEXE: ALUSrcA=1, ALUSrcB=00, ALUop=10. Go to RTWB.
- RTWB: RegWrite=1, RegDst=1. Go to FETCH.
- BEQ: ALUSrcA=1, ALUop=01, PCWriteCond=1, PCSource=01. Go to FETCH.
- JMP: PCWrite=1, PCSource=10. Go to FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10. Go to ADDIWB.
- ADDIWB: RegWrite=1. Go to FETCH.
- Cycle counts with zero memory wait: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each wait cycle (mem_ready=0) adds one cycle.
- retired increments by 1 on the edge leaving MEMWB, RTWB, BEQ, JMP, ADDIWB, or MEMWR with mem_ready=1. It wraps modulo 2^CNT_W.
- mem_ready is ignored in every state except FETCH, MEMRD and MEMWR.
- reset takes priority over every transition and over the counter increment, including mid-instruction and during a memory stall.
- opCode is sampled only in DECODE and MEMADR. Changes to opCode in other states have no effect.

Test Plan:
- Reset, then lw (100011) with mem_ready tied to 1 → states 0,1,2,3,4,0. MemToReg=RegWrite=1 only in state 4. retired goes 0→1.
- R-type (000000) then addi (001000), mem_ready=1 → states 0,1,6,7 then 0,1,10,11. RegDst=1 in state 7, 0 in state 11. ALUop=10 in state 6. retired=2.
- sw (101011) with mem_ready held low for 3 cycles in MEMWR → state 5 for 4 cycles with MemWrite=1 and IorD=1. retired increments only on the cycle where mem_ready=1.
- beq (000100) and j (000010) → BEQ cycle shows PCWriteCond=1, ALUop=01, PCSource=01. JMP cycle shows PCWrite=1, PCSource=10. Each takes 3 cycles.
- Illegal opcode 010101 → illegal_op=1 for exactly one cycle (state 1), next state 0, retired unchanged.
- Assert reset during a MEMRD stall → next state 0, retired=0. PCWrite and IRWrite stay 0 while reset is high, even if mem_ready=1.
